// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I main controller.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Moore control word decoded from the state register
  typedef struct packed {
    logic       pcupdate;
    logic       branch;
    logic       regwrite;
    logic       memwrite;
    logic       irwrite;
    logic       adrsrc;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       illegal_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = ctrl_t'(15'h0000);

endpackage

// File: rtl/mc_controller_outdec.sv
// Pure state -> control word decoder (no handshake gating here).
module mc_outdec
  import mc_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Decode the Moore control word; unlisted fields stay at zero
  always_comb begin
    ctrl = CTRL_NONE;
    case (state)
      FETCH: begin
        ctrl.adrsrc    = 1'b0;
        ctrl.alusrca   = SRCA_PC;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.aluop     = ALUOP_ADD;
        ctrl.resultsrc = RES_ALURESULT;
        ctrl.irwrite   = 1'b1;
        ctrl.pcupdate  = 1'b1;
      end
      DECODE: begin
        ctrl.alusrca = SRCA_OLDPC;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMADR: begin
        ctrl.alusrca = SRCA_RS1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMREAD: begin
        ctrl.adrsrc    = 1'b1;
        ctrl.resultsrc = RES_ALUOUT;
      end
      MEMWB: begin
        ctrl.resultsrc = RES_DATA;
        ctrl.regwrite  = 1'b1;
      end
      MEMWRITE: begin
        ctrl.adrsrc    = 1'b1;
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.memwrite  = 1'b1;
      end
      EXECUTER: begin
        ctrl.alusrca = SRCA_RS1;
        ctrl.alusrcb = SRCB_RS2;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        ctrl.alusrca = SRCA_RS1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.regwrite  = 1'b1;
      end
      BEQ: begin
        ctrl.alusrca   = SRCA_RS1;
        ctrl.alusrcb   = SRCB_RS2;
        ctrl.aluop     = ALUOP_SUB;
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      JAL: begin
        ctrl.alusrca   = SRCA_OLDPC;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.aluop     = ALUOP_ADD;
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.pcupdate  = 1'b1;
      end
      TRAP: begin
        ctrl.illegal_op = 1'b1;
      end
      default: begin
        ctrl = CTRL_NONE;
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Main control FSM of the multicycle RV32I core: state sequencing plus
// the memory-ready gating of the fetch strobes.
module mc_controller
  import mc_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       pcupdate,
  output logic       branch,
  output logic       regwrite,
  output logic       memwrite,
  output logic       irwrite,
  output logic       adrsrc,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       illegal_op
);

  state_t state_r;
  state_t next_state_s;
  ctrl_t  ctrl_s;
  logic   ready_s;
  logic   fetch_s;

  // With waiting disabled every access completes in one cycle
  assign ready_s = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign fetch_s = (state_r == FETCH);

  // State register; reset always restarts at FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state sequencing; op only matters in DECODE and MEMADR
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      FETCH:    next_state_s = ready_s ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state_s = MEMADR;
          OP_R:         next_state_s = EXECUTER;
          OP_I:         next_state_s = EXECUTEI;
          OP_BEQ:       next_state_s = BEQ;
          OP_JAL:       next_state_s = JAL;
          default:      next_state_s = TRAP;
        endcase
      end
      MEMADR:   next_state_s = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  next_state_s = ready_s ? MEMWB : MEMREAD;
      MEMWB:    next_state_s = FETCH;
      MEMWRITE: next_state_s = ready_s ? FETCH : MEMWRITE;
      EXECUTER: next_state_s = ALUWB;
      EXECUTEI: next_state_s = ALUWB;
      ALUWB:    next_state_s = FETCH;
      BEQ:      next_state_s = FETCH;
      JAL:      next_state_s = ALUWB;
      TRAP:     next_state_s = TRAP;
      default:  next_state_s = FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state (state_r),
    .ctrl  (ctrl_s)
  );

  // Drive outputs: fetch strobes wait for memory, all enables die during reset
  always_comb begin
    resultsrc  = ctrl_s.resultsrc;
    alusrca    = ctrl_s.alusrca;
    alusrcb    = ctrl_s.alusrcb;
    aluop      = ctrl_s.aluop;
    adrsrc     = ctrl_s.adrsrc;
    branch     = ctrl_s.branch;
    illegal_op = ctrl_s.illegal_op;
    irwrite    = ctrl_s.irwrite  & ready_s & ~reset;
    pcupdate   = ctrl_s.pcupdate & (ready_s | ~fetch_s) & ~reset;
    regwrite   = ctrl_s.regwrite & ~reset;
    memwrite   = ctrl_s.memwrite & ~reset;
  end

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller against a per-instruction step model.
module tb_mc_controller;
  import mc_pkg::*;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic       mem_ready;
  logic       pcupdate, branch, regwrite, memwrite, irwrite, adrsrc, illegal_op;
  logic [1:0] resultsrc, alusrca, alusrcb, aluop;

  int n_tests = 0;
  int n_fail  = 0;

  mc_controller #(.MEM_WAIT_EN(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .mem_ready  (mem_ready),
    .pcupdate   (pcupdate),
    .branch     (branch),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .adrsrc     (adrsrc),
    .resultsrc  (resultsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed word: {pcu,br,rw,mw,ir,adr,res[2],a[2],b[2],aop[2],ill}
  wire [14:0] obs = {pcupdate, branch, regwrite, memwrite, irwrite, adrsrc,
                     resultsrc, alusrca, alusrcb, aluop, illegal_op};

  localparam logic [14:0] FETCH_STROBES = 15'h4400;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] w(input bit pcu, input bit br, input bit rw, input bit mw,
                                    input bit ir, input bit adr, input logic [1:0] res,
                                    input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] aop, input bit ill);
    return {pcu, br, rw, mw, ir, adr, res, a, b, aop, ill};
  endfunction

  function automatic logic [14:0] fetch_w();
    return w(1, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
  endfunction

  // Run one instruction through the model: a list of steps, some of which
  // wait for mem_ready; compare every cycle and the total cycle count.
  task automatic run_instr(input logic [6:0] iop, input string iname, input int base_cycles);
    logic [14:0] sw_q[$];
    bit          wt_q[$];
    int          i = 0;
    int          cyc = 0;
    int          waits = 0;
    int          lows = 0;
    logic [14:0] exp;
    sw_q.push_back(fetch_w());                                          wt_q.push_back(1);
    sw_q.push_back(w(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0)); wt_q.push_back(0);
    case (iop)
      OP_LW: begin
        sw_q.push_back(w(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0)); wt_q.push_back(0);
        sw_q.push_back(w(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0)); wt_q.push_back(1);
        sw_q.push_back(w(0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0)); wt_q.push_back(0);
      end
      OP_SW: begin
        sw_q.push_back(w(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0)); wt_q.push_back(0);
        sw_q.push_back(w(0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0)); wt_q.push_back(1);
      end
      OP_R, OP_I: begin
        sw_q.push_back(w(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, (iop == OP_R) ? 2'b00 : 2'b01, 2'b10, 0));
        wt_q.push_back(0);
        sw_q.push_back(w(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0)); wt_q.push_back(0);
      end
      OP_BEQ: begin
        sw_q.push_back(w(0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0)); wt_q.push_back(0);
      end
      OP_JAL: begin
        sw_q.push_back(w(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0)); wt_q.push_back(0);
        sw_q.push_back(w(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0)); wt_q.push_back(0);
      end
      default: begin
        for (int t = 0; t < 25; t++) begin
          sw_q.push_back(w(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1)); wt_q.push_back(0);
        end
      end
    endcase
    while (i < sw_q.size() && cyc < 64) begin
      if (wt_q[i] && lows < 3 && $urandom_range(0, 2) == 0) begin
        mem_ready = 1'b0;
      end else if (wt_q[i]) begin
        mem_ready = 1'b1;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      op = (i == 0) ? 7'($urandom_range(0, 127)) : iop;
      @(negedge clk);
      exp = sw_q[i];
      if (i == 0 && !mem_ready) exp = exp & ~FETCH_STROBES;
      check($sformatf("%s_step%0d", iname, i), {17'h0, obs}, {17'h0, exp});
      cyc++;
      if (!wt_q[i] || mem_ready) begin
        i++;
        lows = 0;
      end else begin
        waits++;
        lows++;
      end
      @(posedge clk);
      #1;
    end
    check($sformatf("%s_cycles", iname), cyc, base_cycles + waits);
  endtask

  logic [6:0] ops[6];
  string      names[6];
  int         bases[6];

  initial begin
    ops   = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
    names = '{"lw", "sw", "rtype", "itype", "beq", "jal"};
    bases = '{5, 4, 4, 4, 3, 4};

    // Power-on reset: enables forced low even with mem_ready high
    reset = 1'b1;
    op = 7'h00;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_enables", {28'h0, irwrite, pcupdate, regwrite, memwrite}, 32'h0);
    check("reset_illegal", {31'h0, illegal_op}, 32'h0);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("post_reset_fetch", {17'h0, obs}, {17'h0, fetch_w() & ~FETCH_STROBES});

    for (int k = 0; k < 150; k++) begin
      int r;
      r = $urandom_range(0, 5);
      run_instr(ops[r], names[r], bases[r]);
    end

    // Asynchronous reset in the middle of a stalled store
    op = OP_SW;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    check("sw_stall_memwrite", {31'h0, memwrite}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_memwrite", {31'h0, memwrite}, 32'h0);
    check("async_reset_word", {17'h0, obs}, {17'h0, fetch_w() & ~FETCH_STROBES});
    mem_ready = 1'b1;
    #1;
    check("reset_forces_irwrite", {31'h0, irwrite}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("release_fetch_word", {17'h0, obs}, {17'h0, fetch_w()});
    mem_ready = 1'b0;
    @(posedge clk); #1;

    // Unsupported opcode traps until reset
    run_instr(7'b1110011, "trap", 27);
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("trap_reset_illegal", {31'h0, illegal_op}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, 5);
      run_instr(ops[r], names[r], bases[r]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
